// File: rtl/timer_pkg.sv
// Shared constants and helpers for the memory-mapped interval timer.
package timer_pkg;

  localparam logic [31:0] ADDR_TCNT = 32'hFFFFF100;
  localparam logic [31:0] ADDR_TLIM = 32'hFFFFF104;
  localparam logic [31:0] ADDR_TCTL = 32'hFFFFF108;

  localparam int CTL_READY = 0;
  localparam int CTL_OVR   = 2;
  localparam int CTL_IE    = 8;

  function automatic logic [31:0] ctl_fmt(input logic ready, input logic ovr, input logic ie);
    logic [31:0] r;
    r            = '0;
    r[CTL_READY] = ready;
    r[CTL_OVR]   = ovr;
    r[CTL_IE]    = ie;
    return r;
  endfunction

endpackage

// File: rtl/timer_if.sv
// MEM-stage I/O bus as seen by the timer: address/store in, load data and irq out.
interface timer_if #(parameter int DBITS = 32);
  logic [DBITS-1:0] addr;
  logic             wr_en;
  logic [DBITS-1:0] wr_data;
  logic             sel;
  logic [DBITS-1:0] rd_data;
  logic             irq;

  modport master (output addr, output wr_en, output wr_data,
                  input  sel,  input  rd_data, input irq);
  modport slave  (input  addr, input  wr_en, input  wr_data,
                  output sel,  output rd_data, output irq);
endinterface

// File: rtl/timer_dev_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE clocks, restartable via clr.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == PW'(PRESCALE - 1));

  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (clr || tick) pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/timer_dev.sv
// Interval timer on the I/O bus: TCNT/TLIM/TCTL registers, limit flag,
// overrun flag and level interrupt.
module timer_dev
  import timer_pkg::*;
#(
  parameter int               DBITS    = 32,
  parameter int               PRESCALE = 50000,
  parameter logic [DBITS-1:0] ADDRTCNT = DBITS'(ADDR_TCNT),
  parameter logic [DBITS-1:0] ADDRTLIM = DBITS'(ADDR_TLIM),
  parameter logic [DBITS-1:0] ADDRTCTL = DBITS'(ADDR_TCTL)
) (
  input  logic     clk,
  input  logic     reset,
  timer_if.slave   bus
);
  logic [DBITS-1:0] tcnt_q, tcnt_d, tlim_q, tlim_d;
  logic             ready_q, ready_d, ovr_q, ovr_d, ie_q, ie_d;
  logic             hit_cnt, hit_lim, hit_ctl;
  logic             wr_cnt, wr_lim, wr_ctl;
  logic             tick, lim_evt;

  assign hit_cnt = (bus.addr == ADDRTCNT);
  assign hit_lim = (bus.addr == ADDRTLIM);
  assign hit_ctl = (bus.addr == ADDRTCTL);
  assign wr_cnt  = bus.wr_en & hit_cnt;
  assign wr_lim  = bus.wr_en & hit_lim;
  assign wr_ctl  = bus.wr_en & hit_ctl;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (wr_cnt | wr_lim),
    .tick  (tick)
  );

  // A counter or limit write overrides whatever the tick would have done.
  assign lim_evt = tick & ~wr_cnt & ~wr_lim & (tlim_q != '0) &
                   (tcnt_q == tlim_q - DBITS'(1));

  always_comb begin
    tcnt_d  = tcnt_q;
    tlim_d  = tlim_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ie_d    = ie_q;
    if (wr_cnt)       tcnt_d = bus.wr_data;
    else if (wr_lim)  tcnt_d = '0;
    else if (lim_evt) tcnt_d = '0;
    else if (tick)    tcnt_d = tcnt_q + DBITS'(1);
    if (wr_lim) tlim_d = bus.wr_data;
    // Software may only clear flags; a same-cycle hardware set still wins.
    if (wr_ctl) begin
      ready_d = ready_q & bus.wr_data[CTL_READY];
      ovr_d   = ovr_q   & bus.wr_data[CTL_OVR];
      ie_d    = bus.wr_data[CTL_IE];
    end
    if (lim_evt) begin
      ready_d = 1'b1;
      if (ready_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q  <= '0;
      tlim_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tlim_q  <= tlim_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (hit_cnt)      bus.rd_data = tcnt_q;
    else if (hit_lim) bus.rd_data = tlim_q;
    else if (hit_ctl) bus.rd_data = DBITS'(ctl_fmt(ready_q, ovr_q, ie_q));
  end

  assign bus.sel = hit_cnt | hit_lim | hit_ctl;
  assign bus.irq = ready_q & ie_q;
endmodule
